// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing constants and types
// Purpose: 800x600@60 timing constants, their totals and RGB565 black. Both the
//          VGA driver and the pixel generator use this package, so the two sides
//          always agree on the timing.
// Ports:   none (package)
package vga_timing_pkg;

    typedef logic [10:0] coord_t;
    typedef logic [15:0] rgb565_t;

    localparam coord_t H_SYNC_DEF  = 11'd128;
    localparam coord_t H_BACK_DEF  = 11'd88;
    localparam coord_t H_DISP_DEF  = 11'd800;
    localparam coord_t H_FRONT_DEF = 11'd40;

    localparam coord_t V_SYNC_DEF  = 11'd4;
    localparam coord_t V_BACK_DEF  = 11'd23;
    localparam coord_t V_DISP_DEF  = 11'd600;
    localparam coord_t V_FRONT_DEF = 11'd1;

    localparam rgb565_t BLACK = 16'h0000;

    // Length of a full line or frame: sync + back porch + display + front porch.
    function automatic coord_t span4(input coord_t a, input coord_t b,
                                     input coord_t c, input coord_t d);
        return a + b + c + d;
    endfunction

    localparam coord_t H_TOTAL_DEF = span4(H_SYNC_DEF, H_BACK_DEF, H_DISP_DEF, H_FRONT_DEF);
    localparam coord_t V_TOTAL_DEF = span4(V_SYNC_DEF, V_BACK_DEF, V_DISP_DEF, V_FRONT_DEF);

endpackage

// File: rtl/vga_driver_if.sv
// rtl/vga_driver_if.sv - pixel request and video output bundle of the VGA driver
// Purpose: groups the pixel-generator handshake (coordinates out, data back) and
//          the video outputs toward the DAC/encoder.
// Ports:   master - driver side: drives coordinates and video, receives pixel_data
//          slave  - consumer side: pixel generator and video sink
interface vga_driver_if;
    import vga_timing_pkg::*;

    rgb565_t pixel_data;
    coord_t  pixel_xpos;
    coord_t  pixel_ypos;
    logic    vga_hs;
    logic    vga_vs;
    logic    vga_de;
    rgb565_t vga_rgb;
    logic    frame_start;

    modport master (
        input  pixel_data,
        output pixel_xpos, pixel_ypos,
        output vga_hs, vga_vs, vga_de, vga_rgb, frame_start
    );

    modport slave (
        output pixel_data,
        input  pixel_xpos, pixel_ypos,
        input  vga_hs, vga_vs, vga_de, vga_rgb, frame_start
    );

endinterface

// File: rtl/vga_driver.sv
// rtl/vga_driver.sv - VGA timing generator with one-cycle-early pixel requests
// Purpose: free-running horizontal/vertical counters; sync, enable, coordinate
//          requests and colour gating decode combinationally from them.
// Ports:   vga_clk - pixel clock, single domain
//          sys_rst - asynchronous active-high reset, forces both counters to 0
//          vid     - vga_driver_if.master: pixel_data in; pixel_xpos/pixel_ypos,
//                    vga_hs, vga_vs, vga_de, vga_rgb, frame_start out
module vga_driver
    import vga_timing_pkg::*;
#(
    parameter coord_t H_SYNC   = H_SYNC_DEF,
    parameter coord_t H_BACK   = H_BACK_DEF,
    parameter coord_t H_DISP   = H_DISP_DEF,
    parameter coord_t H_FRONT  = H_FRONT_DEF,
    parameter coord_t V_SYNC   = V_SYNC_DEF,
    parameter coord_t V_BACK   = V_BACK_DEF,
    parameter coord_t V_DISP   = V_DISP_DEF,
    parameter coord_t V_FRONT  = V_FRONT_DEF,
    parameter logic   SYNC_POL = 1'b0
) (
    input  logic         vga_clk,
    input  logic         sys_rst,
    vga_driver_if.master vid
);

    localparam coord_t H_TOTAL = span4(H_SYNC, H_BACK, H_DISP, H_FRONT);
    localparam coord_t V_TOTAL = span4(V_SYNC, V_BACK, V_DISP, V_FRONT);

    // Window edges; "END" values are exclusive.
    localparam coord_t H_DE_BEG  = H_SYNC + H_BACK;
    localparam coord_t H_DE_END  = H_DE_BEG + H_DISP;
    localparam coord_t H_REQ_BEG = H_DE_BEG - 11'd1;
    localparam coord_t H_REQ_END = H_DE_END - 11'd1;
    localparam coord_t V_ACT_BEG = V_SYNC + V_BACK;
    localparam coord_t V_ACT_END = V_ACT_BEG + V_DISP;

    coord_t cnt_h;
    coord_t cnt_v;
    logic   line_end;
    logic   vline_act;
    logic   data_req;
    logic   de;

    assign line_end = (cnt_h == H_TOTAL - 11'd1);

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_h <= '0;
            cnt_v <= '0;
        end else begin
            if (line_end) begin
                cnt_h <= '0;
                cnt_v <= (cnt_v == V_TOTAL - 11'd1) ? '0 : cnt_v + 11'd1;
            end else begin
                cnt_h <= cnt_h + 11'd1;
            end
        end
    end

    assign vline_act = (cnt_v >= V_ACT_BEG) && (cnt_v < V_ACT_END);
    assign de        = vline_act && (cnt_h >= H_DE_BEG) && (cnt_h < H_DE_END);

    // The pixel generator registers its answer, so coordinates go out one
    // cycle before the matching vga_de cycle.
    assign data_req  = vline_act && (cnt_h >= H_REQ_BEG) && (cnt_h < H_REQ_END);

    // The subtractions only reach the outputs inside the request window, where
    // they cannot underflow.
    assign vid.pixel_xpos  = data_req ? coord_t'(cnt_h - H_REQ_BEG) : '0;
    assign vid.pixel_ypos  = data_req ? coord_t'(cnt_v - V_ACT_BEG) : '0;

    assign vid.vga_hs      = (cnt_h < H_SYNC) ? SYNC_POL : ~SYNC_POL;
    assign vid.vga_vs      = (cnt_v < V_SYNC) ? SYNC_POL : ~SYNC_POL;
    assign vid.vga_de      = de;
    assign vid.vga_rgb     = de ? vid.pixel_data : BLACK;
    assign vid.frame_start = (cnt_h == '0) && (cnt_v == '0);

endmodule
